ctrl_exposure_seq: RTL and testbench
====================================

CTRL_EXPOSURE_SEQ -- requirements
Module: ctrl_exposure_seq

Interface
REQ-001 SHALL have parameter TICKS_PER_UNIT, default 1: Clk cycles per EX_time unit; legal values are 1..65535.
REQ-002 SHALL have parameter EX_MIN, default 2: lowest exposure length accepted, in units.
REQ-003 SHALL have parameter EX_MAX, default 30: highest exposure length accepted, in units.
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port Init, input, 1 bit: start request, synchronous to Clk, level-sampled.
REQ-007 SHALL have port EX_time, input, 5 bits: exposure length in units, unsigned.
REQ-008 SHALL have port Erase, output, 1 bit: pixel erase, active-high.
REQ-009 SHALL have port Expose, output, 1 bit: pixel expose, active-high.
REQ-010 SHALL have port NRE_1, output, 1 bit: row-1 readout enable, active-low.
REQ-011 SHALL have port NRE_2, output, 1 bit: row-2 readout enable, active-low.
REQ-012 SHALL have port ADC, output, 1 bit: ADC sample strobe, active-high.
REQ-013 SHALL have port Busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port Done, output, 1 bit: one-cycle pulse in the final readout cycle.

Function
REQ-015 SHALL implement an FSM with three states, IDLE, EXPOSE and READOUT, and SHALL drive every output from registers.
REQ-016 In IDLE, outputs SHALL be: Erase=1, Expose=0, NRE_1=1, NRE_2=1, ADC=0, Busy=0, Done=0.
REQ-017 When Init=1 is sampled in IDLE, the FSM SHALL enter EXPOSE at that edge.
- At the same edge it SHALL latch the clamped value of EX_time as N.
REQ-018 The clamp SHALL map EX_time<EX_MIN to EX_MIN, EX_time>EX_MAX to EX_MAX, and pass all other values unchanged.
REQ-019 In EXPOSE, outputs SHALL be: Erase=0, Expose=1, Busy=1.
- EXPOSE SHALL last exactly N*TICKS_PER_UNIT cycles.
- Timing SHALL use a prescaler counter plus a 5-bit unit down-counter; no multiplier.
REQ-020 Changes on EX_time while Busy=1 SHALL have no effect on the running sequence.
REQ-021 READOUT SHALL last exactly 4 cycles, with Erase=0, Expose=0 and Busy=1 throughout:
- R0: NRE_1=0, ADC=0.
- R1: NRE_1=0, ADC=1.
- R2: NRE_2=0, ADC=0.
- R3: NRE_2=0, ADC=1, Done=1.
REQ-022 NRE_1 and NRE_2 SHALL never be low in the same cycle.
REQ-023 From R3 the FSM SHALL return to IDLE.
- If Init=1 is sampled at the R3 edge, it SHALL be ignored.
- A new sequence SHALL require Init=1 sampled in IDLE, so the earliest restart is one cycle after Done.
REQ-024 Init SHALL be ignored while Busy=1.
- A held Init=1 SHALL start a new sequence on the first IDLE cycle.

Reset
REQ-025 While Reset=0, the FSM SHALL be held in IDLE, independent of Clk.
- Outputs SHALL be at the REQ-016 values.
- Counters and N SHALL be 0.
REQ-026 Reset=0 during EXPOSE or READOUT SHALL abort the sequence immediately.
- Done SHALL NOT be asserted for the aborted sequence.
REQ-027 After Reset returns high, the first start SHALL need a fresh Init=1 sampled in IDLE.

Verification
(All scenarios use TICKS_PER_UNIT=1 unless stated; cycle 0 is the edge at which Init is sampled.)
REQ-028 EX_time=10, one-cycle Init pulse:
- Expose=1 for cycles 0-9.
- NRE_1=0 for cycles 10-11, with ADC=1 at cycle 11.
- NRE_2=0 for cycles 12-13, with ADC=1 at cycle 13.
- Done=1 at cycle 13; IDLE (Erase=1) at cycle 14.
REQ-029 Clamping:
- EX_time=0 -> Expose=1 for 2 cycles.
- EX_time=31 -> Expose=1 for 30 cycles.
- EX_time=2 -> Expose=1 for 2 cycles.
REQ-030 EX_time=5, then EX_time changed to 20 at cycle 2 -> Expose=1 for 5 cycles only; Init pulses during Busy produce no extra sequence.
REQ-031 Init held high continuously with EX_time=3:
- Sequences start at cycles 0, 8 and 16.
- Each sequence has Expose for 3 cycles and readout for 4 cycles.
- Done=1 at cycles 6, 14 and 22.
REQ-032 Reset=0 asserted mid-cycle during EXPOSE (EX_time=10, at cycle 4):
- Outputs return to the REQ-016 values before the next Clk edge.
- No Done is asserted.
- After release, Init restarts a full 10-unit exposure.
REQ-033 TICKS_PER_UNIT=4, EX_time=3 -> Expose=1 for exactly 12 cycles, and the readout timing is unchanged.

Source files
------------

// File: rtl/ctrl_exposure_seq.sv
// Pixel exposure sequencer.
// After a start request it runs a clamped-length exposure window and then a
// fixed four-cycle two-row readout. Every output comes straight from a register.
module ctrl_exposure_seq #(
   parameter int TICKS_PER_UNIT = 1,
   parameter int EX_MIN         = 2,
   parameter int EX_MAX         = 30
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Init,
   input  logic [4:0] EX_time,
   output logic       Erase,
   output logic       Expose,
   output logic       NRE_1,
   output logic       NRE_2,
   output logic       ADC,
   output logic       Busy,
   output logic       Done
);

   typedef enum logic [1:0] {IDLE, EXPOSE, READOUT} state_t;

   // Field order matches the output port order.
   typedef struct packed {
      logic erase;
      logic expose;
      logic nre_1;
      logic nre_2;
      logic adc;
      logic busy;
      logic done;
   } seq_out_t;

   localparam seq_out_t OUT_IDLE = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam seq_out_t OUT_EXP  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
   localparam seq_out_t OUT_R0   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   localparam seq_out_t OUT_R1   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam seq_out_t OUT_R2   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam seq_out_t OUT_R3   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

   localparam logic [15:0] PRESC_RELOAD = 16'(TICKS_PER_UNIT - 1);
   localparam logic [4:0]  MIN_U        = 5'(EX_MIN);
   localparam logic [4:0]  MAX_U        = 5'(EX_MAX);

   state_t      state;
   seq_out_t    outs;
   logic [15:0] presc;   // clocks left in the current unit, minus one
   logic [4:0]  units;   // loaded with N at start, then counts down the remaining units
   logic [1:0]  phase;   // readout step R0..R3

   function automatic logic [4:0] clamp_ex(input logic [4:0] t);
      if (t < MIN_U)      return MIN_U;
      else if (t > MAX_U) return MAX_U;
      else                return t;
   endfunction

   // Sequencer FSM. Outputs are registered together with the state transition.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
         outs  <= OUT_IDLE;
         presc <= '0;
         units <= '0;
         phase <= '0;
      end else begin
         case (state)
            IDLE: begin
               // EX_time is sampled only here, so later changes cannot disturb a running sequence.
               if (Init) begin
                  state <= EXPOSE;
                  outs  <= OUT_EXP;
                  units <= clamp_ex(EX_time);
                  presc <= PRESC_RELOAD;
               end
            end
            EXPOSE: begin
               if (presc != '0) begin
                  presc <= presc - 16'd1;
               end else if (units != 5'd1) begin
                  units <= units - 5'd1;
                  presc <= PRESC_RELOAD;
               end else begin
                  units <= '0;
                  state <= READOUT;
                  phase <= 2'd0;
                  outs  <= OUT_R0;
               end
            end
            READOUT: begin
               phase <= phase + 2'd1;
               case (phase)
                  2'd0: outs <= OUT_R1;
                  2'd1: outs <= OUT_R2;
                  2'd2: outs <= OUT_R3;
                  default: begin
                     // Init seen on this edge is dropped. The restart needs one IDLE cycle first.
                     state <= IDLE;
                     outs  <= OUT_IDLE;
                  end
               endcase
            end
            default: begin
               state <= IDLE;
               outs  <= OUT_IDLE;
            end
         endcase
      end
   end

   assign Erase  = outs.erase;
   assign Expose = outs.expose;
   assign NRE_1  = outs.nre_1;
   assign NRE_2  = outs.nre_2;
   assign ADC    = outs.adc;
   assign Busy   = outs.busy;
   assign Done   = outs.done;

endmodule

// File: tb/tb_ctrl_exposure_seq.sv
// Directed bench for ctrl_exposure_seq. It checks the outputs cycle by cycle
// against hand-derived vectors in the order {Erase,Expose,NRE_1,NRE_2,ADC,Busy,Done}.
module tb_ctrl_exposure_seq;

   localparam logic [6:0] V_IDLE = 7'b1011000;
   localparam logic [6:0] V_EXP  = 7'b0111010;
   localparam logic [6:0] V_R0   = 7'b0001010;
   localparam logic [6:0] V_R1   = 7'b0001110;
   localparam logic [6:0] V_R2   = 7'b0010010;
   localparam logic [6:0] V_R3   = 7'b0010111;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Init = 1'b0;
   logic       Init4 = 1'b0;
   logic [4:0] EX_time = 5'd0;

   logic e1, x1, n11, n21, a1, b1, d1;
   logic e4, x4, n14, n24, a4, b4, d4;
   logic [6:0] o1, o4;

   int nchk = 0;
   int nerr = 0;

   assign o1 = {e1, x1, n11, n21, a1, b1, d1};
   assign o4 = {e4, x4, n14, n24, a4, b4, d4};

   always #5 Clk = ~Clk;

   ctrl_exposure_seq #(.TICKS_PER_UNIT(1), .EX_MIN(2), .EX_MAX(30)) dut1 (
      .Clk(Clk), .Reset(Reset), .Init(Init), .EX_time(EX_time),
      .Erase(e1), .Expose(x1), .NRE_1(n11), .NRE_2(n21), .ADC(a1), .Busy(b1), .Done(d1)
   );

   ctrl_exposure_seq #(.TICKS_PER_UNIT(4), .EX_MIN(2), .EX_MAX(30)) dut4 (
      .Clk(Clk), .Reset(Reset), .Init(Init4), .EX_time(EX_time),
      .Erase(e4), .Expose(x4), .NRE_1(n14), .NRE_2(n24), .ADC(a4), .Busy(b4), .Done(d4)
   );

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Expected vector for cycle c of a sequence whose exposure lasts len cycles.
   function automatic logic [6:0] expv(input int c, input int len);
      if (c < len)           return V_EXP;
      else if (c == len)     return V_R0;
      else if (c == len + 1) return V_R1;
      else if (c == len + 2) return V_R2;
      else if (c == len + 3) return V_R3;
      else                   return V_IDLE;
   endfunction

   // Must be called at a negedge. Raises Init on the selected DUT and checks
   // cycles 0..len+4. hold keeps Init high. mid changes EX_time to 20 at cycle 2
   // and pulses Init while the sequence is busy.
   task automatic run_seq(input string tag, input logic [4:0] ex, input int len,
                          input bit sel4, input bit hold, input bit mid);
      EX_time = ex;
      if (sel4) Init4 = 1'b1; else Init = 1'b1;
      for (int c = 0; c <= len + 4; c++) begin
         @(negedge Clk);
         if (c == 0 && !hold) begin
            Init  = 1'b0;
            Init4 = 1'b0;
         end
         if (mid && c == 2) begin
            EX_time = 5'd20;
            Init    = 1'b1;
         end
         if (mid && c == 3) Init = 1'b0;
         chk($sformatf("%s c%0d", tag, c), sel4 ? o4 : o1, expv(c, len));
      end
   endtask

   initial begin
      // Reset state: both DUTs show the IDLE vector while reset is held.
      #1 Reset = 1'b0;
      #2;
      chk("reset_async_dut1", o1, V_IDLE);
      chk("reset_async_dut4", o4, V_IDLE);
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      chk("idle_after_reset", o1, V_IDLE);

      // Basic sequence with EX_time=10.
      run_seq("ex10", 5'd10, 10, 1'b0, 1'b0, 1'b0);

      // Clamping at both ends, and the lower limit itself.
      run_seq("ex0_clamp", 5'd0, 2, 1'b0, 1'b0, 1'b0);
      run_seq("ex31_clamp", 5'd31, 30, 1'b0, 1'b0, 1'b0);
      run_seq("ex2_min", 5'd2, 2, 1'b0, 1'b0, 1'b0);

      // A busy-time change of EX_time and an Init pulse during the sequence must be ignored.
      run_seq("ex5_mid", 5'd5, 5, 1'b0, 1'b0, 1'b1);
      @(negedge Clk);
      chk("no_extra_seq", o1, V_IDLE);

      // Init held high: sequences start at cycles 0, 8 and 16.
      run_seq("hold_a", 5'd3, 3, 1'b0, 1'b1, 1'b0);
      run_seq("hold_b", 5'd3, 3, 1'b0, 1'b1, 1'b0);
      run_seq("hold_c", 5'd3, 3, 1'b0, 1'b1, 1'b0);
      Init = 1'b0;
      @(negedge Clk);
      chk("hold_released", o1, V_IDLE);

      // Reset asserted mid-cycle during exposure aborts without a Done pulse.
      EX_time = 5'd10;
      Init = 1'b1;
      for (int c = 0; c <= 4; c++) begin
         @(negedge Clk);
         Init = 1'b0;
         chk($sformatf("abort_pre c%0d", c), o1, V_EXP);
      end
      #1 Reset = 1'b0;
      #1 chk("abort_async", o1, V_IDLE);
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk);
         chk($sformatf("abort_held c%0d", c), o1, V_IDLE);
      end
      Reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge Clk);
         chk($sformatf("abort_no_restart c%0d", c), o1, V_IDLE);
      end
      run_seq("after_abort", 5'd10, 10, 1'b0, 1'b0, 1'b0);

      // Four clocks per unit: 3 units give a 12-cycle exposure, and the readout is unchanged.
      run_seq("tpu4_ex3", 5'd3, 12, 1'b1, 1'b0, 1'b0);
      chk("tpu4_dut1_idle", o1, V_IDLE);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   // Watchdog in case the bench itself stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
